channel_serializer: RTL and testbench



---
 rtl/channel_serializer_if.sv | 30 +++
 rtl/channel_serializer.sv | 110 +++++++++++
 tb/tb_channel_serializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/channel_serializer_if.sv
// Stream bundle for channel_serializer: parallel word in, tagged single-channel elements out.
// Member names are written from the serializer's side (_i into it, _o out of it).
interface channel_serializer_if #(
    parameter int BufferWidth   = 8,
    parameter int InputChannels = 2
);
    localparam int ChanWidth = (InputChannels > 1) ? $clog2(InputChannels) : 1;

    logic [InputChannels-1:0][BufferWidth-1:0] data_i;
    logic                                      valid_i;
    logic                                      ready_o;
    logic [BufferWidth-1:0]                    data_o;
    logic [ChanWidth-1:0]                      channel_o;
    logic                                      last_ch_o;
    logic                                      last_line_o;
    logic                                      valid_o;
    logic                                      ready_i;

    // Serializer side
    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, channel_o, last_ch_o, last_line_o, valid_o
    );

    // Producer/consumer side
    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, channel_o, last_ch_o, last_line_o, valid_o
    );
endinterface

// File: rtl/channel_serializer.sv
// channel_serializer: captures one multi-channel pixel word per handshake and
// emits its channels one per cycle, channel 0 first, tagged with channel index,
// last-channel and end-of-line flags. The next word can load on the same edge
// that the last channel leaves, so back-to-back words stream without bubbles.
module channel_serializer #(
    parameter int BufferWidth   = 8,
    parameter int InputChannels = 2,
    parameter int LineWidth     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    channel_serializer_if.slave   bus
);
    localparam int ChanWidth = (InputChannels > 1) ? $clog2(InputChannels) : 1;
    localparam int PixWidth  = (LineWidth > 1) ? $clog2(LineWidth) : 1;
    localparam logic [ChanWidth-1:0] LastCh  = ChanWidth'(InputChannels - 1);
    localparam logic [PixWidth-1:0]  LastPix = PixWidth'(LineWidth - 1);

    // Occupancy view of (full_q, ch_q); it is decoded, not stored
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_SENDING = 2'd1,
        ST_LAST    = 2'd2
    } state_e;

    logic [InputChannels-1:0][BufferWidth-1:0] word_q, word_d;
    logic                                      full_q, full_d;
    logic [ChanWidth-1:0]                      ch_q,   ch_d;
    logic [PixWidth-1:0]                       pix_q,  pix_d;

    state_e state;
    logic   last_ch;
    logic   in_fire;
    logic   out_fire;

    assign last_ch  = full_q & (ch_q == LastCh);
    assign in_fire  = bus.valid_i & bus.ready_o;
    assign out_fire = bus.valid_o & bus.ready_i;

    // With one channel ch_q never leaves 0, so last_ch == full_q and readiness
    // passes straight through from ready_i whenever the register is occupied.
    assign bus.ready_o     = rst_ni & (~full_q | (last_ch & bus.ready_i));
    assign bus.valid_o     = full_q;
    assign bus.data_o      = word_q[ch_q];
    assign bus.channel_o   = ch_q;
    assign bus.last_ch_o   = last_ch;
    assign bus.last_line_o = last_ch & (pix_q == LastPix);

    // Decode occupancy state from the stored registers
    always_comb begin
        state = ST_EMPTY;
        if (full_q) begin
            state = (ch_q == LastCh) ? ST_LAST : ST_SENDING;
        end
    end

    // Next-state: advance the channel pointer, retire/reload the word, count pixels
    always_comb begin
        word_d = word_q;
        full_d = full_q;
        ch_d   = ch_q;
        pix_d  = pix_q;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    word_d = bus.data_i;
                    full_d = 1'b1;
                    ch_d   = '0;
                end
            end
            ST_SENDING: begin
                if (out_fire) begin
                    ch_d = ch_q + 1'b1;
                end
            end
            ST_LAST: begin
                if (out_fire) begin
                    // Wrap by comparison so non-power-of-two line widths behave
                    pix_d = (pix_q == LastPix) ? '0 : pix_q + 1'b1;
                    ch_d  = '0;
                    if (in_fire) begin
                        word_d = bus.data_i;
                        full_d = 1'b1;
                    end else begin
                        full_d = 1'b0;
                    end
                end
            end
            default: begin
                full_d = 1'b0;
                ch_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any partial word and restarts the line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            full_q <= 1'b0;
            ch_q   <= '0;
            pix_q  <= '0;
        end else begin
            word_q <= word_d;
            full_q <= full_d;
            ch_q   <= ch_d;
            pix_q  <= pix_d;
        end
    end
endmodule

// File: tb/tb_channel_serializer.sv
// Directed bench for channel_serializer: three instances (2, 3 and 1 channels)
// driven in turn from one linear stimulus sequence.
module tb_channel_serializer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    channel_serializer_if #(.BufferWidth(8), .InputChannels(2)) if2 ();
    channel_serializer_if #(.BufferWidth(8), .InputChannels(3)) if3 ();
    channel_serializer_if #(.BufferWidth(8), .InputChannels(1)) if1 ();

    channel_serializer #(.BufferWidth(8), .InputChannels(2), .LineWidth(8)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if2));
    channel_serializer #(.BufferWidth(8), .InputChannels(3), .LineWidth(5)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if3));
    channel_serializer #(.BufferWidth(8), .InputChannels(1), .LineWidth(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back two-channel words: ch0 = base+k, ch1 = base+0x80+k
    task automatic stream8(input logic [7:0] base);
        int         k;
        logic [7:0] lo;
        logic [7:0] exp;
        k  = 0;
        lo = base;
        if2.ready_i = 1'b1;
        if2.valid_i = 1'b1;
        if2.data_i  = {lo + 8'h80, lo};
        for (int e = 0; e < 16; e++) begin
            tick;
            lo  = base + 8'(e / 2);
            exp = (e % 2 == 0) ? lo : lo + 8'h80;
            chk("stream_valid", if2.valid_o, 1);
            chk("stream_chan", if2.channel_o, e % 2);
            chk("stream_data", if2.data_o, exp);
            chk("stream_ready", if2.ready_o, (e % 2 == 1));
            chk("stream_last_line", if2.last_line_o, (e == 15));
            if (e % 2 == 1) begin
                k++;
                if (k < 8) begin
                    lo = base + 8'(k);
                    if2.data_i = {lo + 8'h80, lo};
                end else begin
                    if2.valid_i = 1'b0;
                end
            end
        end
        tick;
        chk("stream_idle", if2.valid_o, 0);
    endtask

    initial begin
        int         kin;
        int         kout;
        int         cout;
        int         ll;
        logic [7:0] exp;

        if2.valid_i = 1'b0; if2.ready_i = 1'b0; if2.data_i = '0;
        if3.valid_i = 1'b0; if3.ready_i = 1'b0; if3.data_i = '0;
        if1.valid_i = 1'b0; if1.ready_i = 1'b0; if1.data_i = '0;
        rst_n = 1'b0;
        tick;
        tick;
        // Reset state
        chk("rst_ready", if2.ready_o, 0);
        chk("rst_valid", if2.valid_o, 0);
        chk("rst_data", if2.data_o, 0);
        chk("rst_chan", if2.channel_o, 0);
        chk("rst_last_line", if2.last_line_o, 0);
        chk("rst_valid3", if3.valid_o, 0);
        chk("rst_valid1", if1.valid_o, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", if2.ready_o, 1);

        // Basic word {ch1=BB, ch0=AA}
        if2.data_i  = {8'hBB, 8'hAA};
        if2.valid_i = 1'b1;
        if2.ready_i = 1'b1;
        tick;
        if2.valid_i = 1'b0;
        chk("basic_c1_valid", if2.valid_o, 1);
        chk("basic_c1_data", if2.data_o, 8'hAA);
        chk("basic_c1_chan", if2.channel_o, 0);
        chk("basic_c1_last_ch", if2.last_ch_o, 0);
        chk("basic_c1_ready", if2.ready_o, 0);
        tick;
        chk("basic_c2_data", if2.data_o, 8'hBB);
        chk("basic_c2_chan", if2.channel_o, 1);
        chk("basic_c2_last_ch", if2.last_ch_o, 1);
        chk("basic_c2_ready", if2.ready_o, 1);
        tick;
        chk("basic_c3_valid", if2.valid_o, 0);

        // Restart the line count, then stream a full line
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        stream8(8'h10);

        // Back-pressure with channel 1 pending
        if2.data_i  = {8'hBB, 8'hAA};
        if2.valid_i = 1'b1;
        if2.ready_i = 1'b1;
        tick;
        if2.valid_i = 1'b0;
        chk("bp_first", if2.data_o, 8'hAA);
        tick;
        if2.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if2.data_i = {8'h5A, 8'hA5};
            tick;
            chk("bp_hold_data", if2.data_o, 8'hBB);
            chk("bp_hold_chan", if2.channel_o, 1);
            chk("bp_hold_valid", if2.valid_o, 1);
            chk("bp_hold_ready", if2.ready_o, 0);
        end
        if2.ready_i = 1'b1;
        #1;
        chk("bp_release_ready", if2.ready_o, 1);
        tick;
        chk("bp_once", if2.valid_o, 0);

        // Asynchronous reset mid-word
        if2.data_i  = {8'h22, 8'h11};
        if2.valid_i = 1'b1;
        tick;
        if2.valid_i = 1'b0;
        chk("arst_pre", if2.data_o, 8'h11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", if2.valid_o, 0);
        chk("arst_data", if2.data_o, 0);
        chk("arst_chan", if2.channel_o, 0);
        chk("arst_last_ch", if2.last_ch_o, 0);
        chk("arst_ready", if2.ready_o, 0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_valid", if2.valid_o, 0);
        chk("arst_rel_ready", if2.ready_o, 1);
        stream8(8'h30);

        // Three channels, five-pixel line, random back-pressure
        kin = 0; kout = 0; cout = 0; ll = 0;
        for (int cyc = 0; cyc < 400 && kout < 10; cyc++) begin
            if3.valid_i = (kin < 10);
            for (int c = 0; c < 3; c++) if3.data_i[c] = 8'(kin * 16 + c);
            if3.ready_i = 1'($urandom_range(0, 1));
            #1;
            if (if3.valid_o && if3.ready_i) begin
                exp = 8'(kout * 16 + cout);
                chk("np2_data", if3.data_o, exp);
                chk("np2_chan", if3.channel_o, cout);
                chk("np2_last_ch", if3.last_ch_o, (cout == 2));
                chk("np2_last_line", if3.last_line_o, (cout == 2) && (kout % 5 == 4));
                if (if3.last_line_o) ll++;
                if (cout == 2) begin
                    cout = 0;
                    kout++;
                end else begin
                    cout++;
                end
            end
            if (if3.valid_i && if3.ready_o) kin++;
            tick;
        end
        if3.valid_i = 1'b0;
        chk("np2_done", kout, 10);
        chk("np2_last_line_count", ll, 2);

        // One channel: full throughput with ready_i held high
        if1.data_i  = 8'hC0;
        if1.valid_i = 1'b1;
        if1.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("one_valid", if1.valid_o, 1);
            chk("one_data", if1.data_o, 8'hC0 + 8'(i));
            chk("one_ready", if1.ready_o, 1);
            chk("one_last_ch", if1.last_ch_o, 1);
            chk("one_chan", if1.channel_o, 0);
            chk("one_last_line", if1.last_line_o, (i % 4 == 3));
            if (i < 5) if1.data_i = 8'hC0 + 8'(i + 1);
            else       if1.valid_i = 1'b0;
        end
        tick;
        chk("one_idle", if1.valid_o, 0);

        // One channel: random valid/ready, order preserved
        kin = 0; kout = 0;
        for (int cyc = 0; cyc < 400 && kout < 10; cyc++) begin
            if1.valid_i = (kin < 10) && ($urandom_range(0, 1) == 1);
            if1.data_i  = 8'hD0 + 8'(kin);
            if1.ready_i = 1'($urandom_range(0, 1));
            #1;
            if (if1.valid_o && if1.ready_i) begin
                chk("one_rnd_data", if1.data_o, 8'hD0 + 8'(kout));
                chk("one_rnd_last_line", if1.last_line_o, ((6 + kout) % 4 == 3));
                kout++;
            end
            if (if1.valid_i && if1.ready_o) kin++;
            tick;
        end
        if1.valid_i = 1'b0;
        chk("one_rnd_done", kout, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
